// File: rtl/adc128s022_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adc128s022_seq_ctrl
//
// Purpose:
//   Runs the 16-SCLK SPI frame of an ADC128S022 (8-channel, 12-bit SAR ADC) on
//   behalf of a NIOS II PIO. Software raises adc_cmd[0] with the wanted channel
//   in adc_cmd[3:1]. The block programs that channel into the ADC, collects the
//   12-bit result and publishes it with a one-clock data_valid pulse.
//
//   The ADC converts the channel that was programmed in the *previous* frame.
//   So by default adc_channel carries the address sent one frame earlier, which
//   is what the returned sample belongs to.
//
// Optional feature (compile-time macro ADC_SAME_CH_EN):
//   When defined, each accepted start runs two back-to-back frames that both
//   program req_addr, with a CS_N-high gap between them. Only the second
//   frame's data is published, and it is tagged with req_addr.
//
// Parameters:
//   CLK_DIV   system clocks per SCLK half-period (legal 4..255)
//   CS_SETUP  clocks from CS_N falling to the first SCLK falling edge; also the
//             CS_N-high hold after the last SCLK rising edge (legal 1..256)
//
// Ports:
//   clk_clk        in   system clock
//   reset_reset_n  in   asynchronous active-low reset
//   adc_cmd[3:0]   in   [0] start level (rising edge triggers), [3:1] channel
//   adc_data[11:0] out  last converted sample
//   adc_channel[2:0] out channel tag of adc_data
//   data_valid     out  one-clock pulse when adc_data/adc_channel update
//   busy           out  high from accepted start through data_valid
//   adc_cs_n       out  ADC chip select (active low)
//   adc_sclk       out  ADC serial clock, idles high
//   adc_din        out  ADC control input (address bits)
//   adc_dout       in   ADC serial output, asynchronous to clk_clk
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module adc128s022_seq_ctrl #(
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [3:0]  adc_cmd,
  output logic [11:0] adc_data,
  output logic [2:0]  adc_channel,
  output logic        data_valid,
  output logic        busy,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Terminal counts; the same 8-bit counter times SETUP, HOLD and each half
  // of an SCLK period.
  localparam logic [7:0] DIV_LAST       = 8'(CLK_DIV - 1);
  localparam logic [7:0] CS_LAST        = 8'(CS_SETUP - 1);
  localparam logic [3:0] LAST_BIT       = 4'd15;
  // Bits 0..3 of the frame carry leading zeros from the ADC; data starts here.
  localparam logic [3:0] FIRST_DATA_BIT = 4'd4;
  // Positions in the frame where the three address bits are driven on DIN.
  localparam logic [3:0] ADDR2_BIT      = 4'd2;
  localparam logic [3:0] ADDR1_BIT      = 4'd3;
  localparam logic [3:0] ADDR0_BIT      = 4'd4;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t      state;
  state_t      state_next;
  logic [7:0]  cnt;
  logic [7:0]  cnt_next;
  logic        phase;        // 0: SCLK-low half of a bit, 1: SCLK-high half
  logic        phase_next;
  logic [3:0]  bit_idx;      // k = 0..15 within the frame
  logic [3:0]  bit_next;
`ifdef ADC_SAME_CH_EN
  logic        second;       // currently running the second (published) frame
  logic        second_next;
`endif

  logic        dout_meta;
  logic        dout_sync;

  logic [3:0]  cmd_reg;      // registered command word
  logic        start_prev;   // previous value of cmd_reg[0] for edge detect
  logic        start;

  logic [2:0]  req_addr;
`ifndef ADC_SAME_CH_EN
  logic [2:0]  prev_addr;    // address programmed by the last completed frame
`endif
  logic [11:0] shift_reg;

  logic        accept;
  logic        shift_en;
  logic        publish;
  logic        cs_n_next;
  logic        sclk_next;
  logic        din_next;
  logic        busy_next;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  // adc_dout changes on SCLK edges that are generated from clk_clk, but the
  // ADC's output delay is not related to clk_clk, so it is synchronised.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      dout_meta <= 1'b0;
      dout_sync <= 1'b0;
    end else begin
      dout_meta <= adc_dout;
      dout_sync <= dout_meta;
    end
  end

  // The whole command word is registered together so the channel is taken
  // from the same PIO write that raised the start bit.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cmd_reg    <= 4'd0;
      start_prev <= 1'b0;
    end else begin
      cmd_reg    <= adc_cmd;
      start_prev <= cmd_reg[0];
    end
  end

  // Edge, not level: a start bit left high never retriggers, and an edge that
  // arrives while a frame runs is simply lost (only IDLE looks at it).
  assign start = cmd_reg[0] & ~start_prev;

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      phase   <= 1'b0;
      bit_idx <= 4'd0;
`ifdef ADC_SAME_CH_EN
      second  <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      phase   <= phase_next;
      bit_idx <= bit_next;
`ifdef ADC_SAME_CH_EN
      second  <= second_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    phase_next  = phase;
    bit_next    = bit_idx;
`ifdef ADC_SAME_CH_EN
    second_next = second;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          state_next  = SETUP;
          cnt_next    = 8'd0;
`ifdef ADC_SAME_CH_EN
          second_next = 1'b0;
`endif
        end
      end

      SETUP: begin
        if (cnt == CS_LAST) begin
          state_next = SHIFT;
          cnt_next   = 8'd0;
          phase_next = 1'b0;
          bit_next   = 4'd0;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end

      SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_next = 8'd0;
          if (!phase) begin
            // End of the low half: SCLK rises.
            phase_next = 1'b1;
          end else if (bit_idx == LAST_BIT) begin
            // End of the high half of bit 15: frame complete.
            state_next = HOLD;
            phase_next = 1'b0;
          end else begin
            // End of the high half: SCLK falls for the next bit.
            phase_next = 1'b0;
            bit_next   = bit_idx + 4'd1;
          end
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end

      HOLD: begin
        if (cnt == CS_LAST) begin
          cnt_next = 8'd0;
`ifdef ADC_SAME_CH_EN
          // The first frame only programs req_addr; run again to read it.
          if (!second) begin
            state_next  = SETUP;
            second_next = 1'b1;
          end else begin
            state_next  = DONE;
          end
`else
          state_next = DONE;
`endif
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: output decode
  // ---------------------------------------------------------------------------
  // The pin-level outputs are decoded from the *next* state and then
  // registered, so CS_N/SCLK/DIN leave flip-flops (no decode glitches on the
  // ADC clock) while still changing on the same edge as the state.
  always_comb begin
    cs_n_next = 1'b1;
    sclk_next = 1'b1;
    din_next  = 1'b0;
    busy_next = (state_next != IDLE);

    accept   = (state == IDLE) && start;
    // Sample on the edge that raises SCLK, only for the 12 data bits.
    shift_en = (state == SHIFT) && !phase && (cnt == DIV_LAST) &&
               (bit_idx >= FIRST_DATA_BIT);
    // DONE is entered only from HOLD, so this is a single-clock strobe.
    publish  = (state_next == DONE);

    if ((state_next == SETUP) || (state_next == SHIFT)) begin
      cs_n_next = 1'b0;
    end

    if (state_next == SHIFT) begin
      sclk_next = phase_next;
      // DIN is held for the whole bit; the ADC latches it on SCLK rising.
      case (bit_next)
        ADDR2_BIT: din_next = req_addr[2];
        ADDR1_BIT: din_next = req_addr[1];
        ADDR0_BIT: din_next = req_addr[0];
        default:   din_next = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      req_addr    <= 3'd0;
`ifndef ADC_SAME_CH_EN
      prev_addr   <= 3'd0;   // ADC powers up addressing channel 0
`endif
      shift_reg   <= 12'd0;
      adc_data    <= 12'd0;
      adc_channel <= 3'd0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      adc_cs_n    <= 1'b1;
      adc_sclk    <= 1'b1;
      adc_din     <= 1'b0;
    end else begin
      // Channel is frozen for the frame; later PIO changes are ignored.
      if (accept) begin
        req_addr <= cmd_reg[3:1];
      end

      // MSB first: DB11 arrives at k=4 and ends up in shift_reg[11].
      if (shift_en) begin
        shift_reg <= {shift_reg[10:0], dout_sync};
      end

      if (publish) begin
        adc_data    <= shift_reg;
`ifdef ADC_SAME_CH_EN
        adc_channel <= req_addr;
`else
        // The sample belongs to the address sent in the previous frame.
        adc_channel <= prev_addr;
        prev_addr   <= req_addr;
`endif
      end

      data_valid <= publish;
      busy       <= busy_next;
      adc_cs_n   <= cs_n_next;
      adc_sclk   <= sclk_next;
      adc_din    <= din_next;
    end
  end

endmodule

// File: tb/tb_adc128s022_seq_ctrl.sv
`timescale 1ns/1ps

module tb_adc128s022_seq_ctrl;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 4;
`ifdef ADC_SAME_CH_EN
  localparam int NF = 2;   // frames per accepted start
`else
  localparam int NF = 1;
`endif
  localparam int FRAME = 2 * CS_SETUP + 32 * CLK_DIV;
  // Counted in clock edges: edge 1 is the first edge that sees adc_cmd[0]=1.
  localparam int LAT   = 2 + NF * FRAME;
  localparam int LIMIT = LAT + 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  cmd = 4'd0;
  logic        adc_dout = 1'b0;
  logic [11:0] adc_data;
  logic [2:0]  adc_channel;
  logic        data_valid;
  logic        busy;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_din;

  adc128s022_seq_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .CS_SETUP (CS_SETUP)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .adc_cmd       (cmd),
    .adc_data      (adc_data),
    .adc_channel   (adc_channel),
    .data_valid    (data_valid),
    .busy          (busy),
    .adc_cs_n      (adc_cs_n),
    .adc_sclk      (adc_sclk),
    .adc_din       (adc_din),
    .adc_dout      (adc_dout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Per-channel conversion results of the ADC model.
  logic [11:0] samp [8] = '{12'h0A5, 12'h123, 12'h456, 12'hFFF,
                            12'h3C3, 12'h5A5, 12'h800, 12'h7E1};

  // ---------------------------------------------------------------------------
  // ADC128S022 model: DOUT changes on SCLK falling, DIN latched on SCLK rising
  // at bits 2..4, new address takes effect only after a complete frame.
  // ---------------------------------------------------------------------------
  logic [2:0] adc_cur = 3'd0;
  logic [2:0] adc_nxt = 3'd0;
  int         fk = 0;            // falling edges seen in the current frame
  int         falls = 0;
  int         cs_lows = 0;
  logic       din_rec [16];

  always @(negedge adc_cs_n) begin
    fk = 0;
    adc_dout = 1'b0;
    cs_lows++;
  end

  always @(posedge adc_cs_n) begin
    if (fk == 16) adc_cur = adc_nxt;
  end

  always @(negedge adc_sclk) begin
    if (!adc_cs_n && fk < 16) begin
      if (fk >= 4) adc_dout = samp[adc_cur][15 - fk];
      else         adc_dout = 1'b0;
      fk++;
      falls++;
    end
  end

  always @(posedge adc_sclk) begin
    if (!adc_cs_n && fk >= 1 && fk <= 16) begin
      din_rec[fk - 1] = adc_din;
      if (fk == 3) adc_nxt[2] = adc_din;
      if (fk == 4) adc_nxt[1] = adc_din;
      if (fk == 5) adc_nxt[0] = adc_din;
    end
  end

  // Cycle monitors, sampled mid-period.
  int dv_cnt = 0;
  int sclk_idle_bad = 0;
  int hold_run = 0;
  int hold_last = 0;
  int hi_run = 0;
  int cs_high_min = 1000;

  always @(negedge clk) begin
    if (data_valid) dv_cnt++;
    if (adc_cs_n && !adc_sclk) sclk_idle_bad++;
    if (!adc_cs_n)       hold_run = 0;
    else if (data_valid) hold_last = hold_run;
    else                 hold_run++;
    // CS_N-high gap between two frames of one busy period.
    if (busy && adc_cs_n && !data_valid) hi_run++;
    else begin
      if (hi_run > 0 && busy && !adc_cs_n && hi_run < cs_high_min) cs_high_min = hi_run;
      hi_run = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [11:0] d;
    logic [2:0]  ch;
  } exp_t;

  exp_t       sb [$];
  logic [2:0] exp_prev = 3'd0;

  task automatic issue(input logic [2:0] ch);
    @(negedge clk);
    cmd = {ch, 1'b1};
`ifdef ADC_SAME_CH_EN
    sb.push_back(exp_t'{d: samp[ch], ch: ch});
`else
    sb.push_back(exp_t'{d: samp[exp_prev], ch: exp_prev});
    exp_prev = ch;
`endif
  endtask

  task automatic drop_start();
    @(negedge clk);
    cmd[0] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_dv(output int n, output bit got);
    n = 0;
    got = 1'b0;
    while (n < LIMIT && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (data_valid) got = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    cmd = 4'd0;
    repeat (2) @(negedge clk);
    checks++; if (adc_data !== 12'd0) begin failures++; $display("FAIL rst_data got=%h want=000", adc_data); end
    checks++; if (adc_channel !== 3'd0) begin failures++; $display("FAIL rst_channel got=%0d want=0", adc_channel); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", data_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (adc_cs_n !== 1'b1) begin failures++; $display("FAIL rst_cs_n got=%b want=1", adc_cs_n); end
    checks++; if (adc_sclk !== 1'b1) begin failures++; $display("FAIL rst_sclk got=%b want=1", adc_sclk); end
    checks++; if (adc_din !== 1'b0) begin failures++; $display("FAIL rst_din got=%b want=0", adc_din); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || adc_cs_n !== 1'b1) begin failures++; $display("FAIL post_rst_idle busy=%b cs_n=%b want 0/1", busy, adc_cs_n); end
    sclk_idle_bad = 0;
    $display("test_reset done");
  endtask

  task automatic test_first_frame();
    int n; bit got; exp_t e; int f0; int c0;
    logic [2:0] din_addr;
    bit din_zero;
    f0 = falls; c0 = cs_lows;
    issue(3'd3);
    wait_dv(n, got);
    checks++;
    if (!got) begin
      failures++; $display("FAIL t1_dv_timeout waited=%0d cycles want<=%0d", n, LIMIT);
    end else begin
      e = sb.pop_front();
      checks++; if (adc_data !== e.d) begin failures++; $display("FAIL t1_data got=%h want=%h", adc_data, e.d); end
      checks++; if (adc_channel !== e.ch) begin failures++; $display("FAIL t1_channel got=%0d want=%0d", adc_channel, e.ch); end
`ifndef ADC_SAME_CH_EN
      checks++; if (n !== LAT) begin failures++; $display("FAIL t1_latency got=%0d want=%0d", n, LAT); end
`endif
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy_at_dv got=%b want=1", busy); end
      din_addr = {din_rec[2], din_rec[3], din_rec[4]};
      checks++; if (din_addr !== 3'd3) begin failures++; $display("FAIL t1_din_addr got=%b want=011", din_addr); end
      din_zero = din_rec[0] | din_rec[1];
      for (int i = 5; i < 16; i++) din_zero |= din_rec[i];
      checks++; if (din_zero !== 1'b0) begin failures++; $display("FAIL t1_din_other got=%b want=0", din_zero); end
      checks++; if (falls - f0 !== 16 * NF) begin failures++; $display("FAIL t1_falls got=%0d want=%0d", falls - f0, 16 * NF); end
      checks++; if (cs_lows - c0 !== NF) begin failures++; $display("FAIL t1_cs_frames got=%0d want=%0d", cs_lows - c0, NF); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || data_valid !== 1'b0) begin failures++; $display("FAIL t1_after_dv busy=%b dv=%b want 0/0", busy, data_valid); end
      $display("test_first_frame ch=3 data=%h channel=%0d latency=%0d", adc_data, adc_channel, n);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit got; exp_t e; int f0;
    drop_start();
    f0 = falls;
    issue(3'd5);
    wait_dv(n, got);
    checks++;
    if (!got) begin
      failures++; $display("FAIL t2_dv_timeout waited=%0d cycles want<=%0d", n, LIMIT);
    end else begin
      e = sb.pop_front();
      checks++; if (adc_data !== e.d) begin failures++; $display("FAIL t2_data got=%h want=%h", adc_data, e.d); end
      checks++; if (adc_channel !== e.ch) begin failures++; $display("FAIL t2_channel got=%0d want=%0d", adc_channel, e.ch); end
      checks++; if (falls - f0 !== 16 * NF) begin failures++; $display("FAIL t2_falls got=%0d want=%0d", falls - f0, 16 * NF); end
      checks++; if (hold_last < CS_SETUP) begin failures++; $display("FAIL t2_cs_hold got=%0d want>=%0d", hold_last, CS_SETUP); end
      checks++; if (sclk_idle_bad !== 0) begin failures++; $display("FAIL t2_sclk_idle low_while_cs_high=%0d want=0", sclk_idle_bad); end
      $display("test_back_to_back ch=5 data=%h channel=%0d hold=%0d", adc_data, adc_channel, hold_last);
    end
    repeat (2) @(negedge clk);
    checks++; if (adc_sclk !== 1'b1) begin failures++; $display("FAIL t2_sclk_idle_high got=%b want=1", adc_sclk); end
  endtask

  task automatic test_start_while_busy();
    int n; bit got; bit early; exp_t e; int d0; int c0;
    drop_start();
    d0 = dv_cnt; c0 = cs_lows;
    issue(3'd0);
    n = 0; got = 1'b0; early = 1'b0;
    while (n < LIMIT && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == 3)  cmd[0] = 1'b0;
      if (n == 50) cmd[0] = 1'b1;
      if (data_valid) got = 1'b1;
      else if (n >= 2 && !busy) early = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++; $display("FAIL t3_dv_timeout waited=%0d cycles want<=%0d", n, LIMIT);
    end else begin
      e = sb.pop_front();
      checks++; if (adc_data !== e.d) begin failures++; $display("FAIL t3_data got=%h want=%h", adc_data, e.d); end
      checks++; if (adc_channel !== e.ch) begin failures++; $display("FAIL t3_channel got=%0d want=%0d", adc_channel, e.ch); end
      checks++; if (early !== 1'b0) begin failures++; $display("FAIL t3_busy_early got=%b want=0", early); end
    end
    repeat (LAT + 50) @(negedge clk);
    checks++; if (dv_cnt - d0 !== 1) begin failures++; $display("FAIL t3_dv_count got=%0d want=1", dv_cnt - d0); end
    checks++; if (cs_lows - c0 !== NF) begin failures++; $display("FAIL t3_frames got=%0d want=%0d", cs_lows - c0, NF); end
    $display("test_start_while_busy ch=0 dv_pulses=%0d frames=%0d", dv_cnt - d0, cs_lows - c0);
  endtask

  task automatic test_reset_mid_frame();
    int n; bit got; exp_t e; int d0;
    drop_start();
    d0 = dv_cnt;
    issue(3'd2);
    n = 0;
    while (!(adc_cs_n === 1'b0 && fk >= 9) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= LIMIT) begin
      failures++; $display("FAIL t4_reach_k8 waited=%0d cycles want<%0d", n, LIMIT);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (adc_cs_n !== 1'b1) begin failures++; $display("FAIL t4_async_cs_n got=%b want=1", adc_cs_n); end
    checks++; if (adc_sclk !== 1'b1) begin failures++; $display("FAIL t4_async_sclk got=%b want=1", adc_sclk); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t4_async_busy got=%b want=0", busy); end
    sb.delete();
    exp_prev = 3'd0;
    cmd = 4'd0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dv_cnt !== d0) begin failures++; $display("FAIL t4_no_dv got=%0d want=%0d", dv_cnt - d0, 0); end
    issue(3'd4);
    wait_dv(n, got);
    checks++;
    if (!got) begin
      failures++; $display("FAIL t4_dv_timeout waited=%0d cycles want<=%0d", n, LIMIT);
    end else begin
      e = sb.pop_front();
      checks++; if (adc_data !== e.d) begin failures++; $display("FAIL t4_data got=%h want=%h", adc_data, e.d); end
      checks++; if (adc_channel !== e.ch) begin failures++; $display("FAIL t4_channel got=%0d want=%0d", adc_channel, e.ch); end
      $display("test_reset_mid_frame next ch=4 data=%h channel=%0d", adc_data, adc_channel);
    end
  endtask

  task automatic test_start_held();
    int n; bit got; exp_t e; int d0; int c0;
    drop_start();
    d0 = dv_cnt; c0 = cs_lows;
    issue(3'd1);
    wait_dv(n, got);
    checks++;
    if (!got) begin
      failures++; $display("FAIL t5_dv_timeout waited=%0d cycles want<=%0d", n, LIMIT);
    end else begin
      e = sb.pop_front();
      checks++; if (adc_data !== e.d) begin failures++; $display("FAIL t5_data got=%h want=%h", adc_data, e.d); end
      checks++; if (adc_channel !== e.ch) begin failures++; $display("FAIL t5_channel got=%0d want=%0d", adc_channel, e.ch); end
`ifndef ADC_SAME_CH_EN
      checks++; if (n !== LAT) begin failures++; $display("FAIL t5_latency got=%0d want=%0d", n, LAT); end
`endif
    end
    repeat (3 * LAT - n) @(negedge clk);
    checks++; if (dv_cnt - d0 !== 1) begin failures++; $display("FAIL t5_held_dv got=%0d want=1", dv_cnt - d0); end
    checks++; if (cs_lows - c0 !== NF) begin failures++; $display("FAIL t5_held_frames got=%0d want=%0d", cs_lows - c0, NF); end
    drop_start();
    issue(3'd6);
    wait_dv(n, got);
    checks++;
    if (!got) begin
      failures++; $display("FAIL t5_retrig_timeout waited=%0d cycles want<=%0d", n, LIMIT);
    end else begin
      e = sb.pop_front();
      checks++; if (adc_data !== e.d) begin failures++; $display("FAIL t5_retrig_data got=%h want=%h", adc_data, e.d); end
      checks++; if (adc_channel !== e.ch) begin failures++; $display("FAIL t5_retrig_channel got=%0d want=%0d", adc_channel, e.ch); end
      $display("test_start_held retrigger data=%h channel=%0d", adc_data, adc_channel);
    end
  endtask

`ifdef ADC_SAME_CH_EN
  task automatic test_same_channel();
    int n; bit got; exp_t e; int d0; int c0;
    drop_start();
    repeat (2) @(negedge clk);
    d0 = dv_cnt; c0 = cs_lows;
    cs_high_min = 1000;
    issue(3'd6);
    wait_dv(n, got);
    checks++;
    if (!got) begin
      failures++; $display("FAIL t6_dv_timeout waited=%0d cycles want<=%0d", n, LIMIT);
    end else begin
      e = sb.pop_front();
      checks++; if (adc_data !== 12'h800 || adc_data !== e.d) begin failures++; $display("FAIL t6_data got=%h want=%h", adc_data, e.d); end
      checks++; if (adc_channel !== 3'd6) begin failures++; $display("FAIL t6_channel got=%0d want=6", adc_channel); end
      checks++; if (cs_high_min < CS_SETUP || cs_high_min == 1000) begin failures++; $display("FAIL t6_gap got=%0d want>=%0d", cs_high_min, CS_SETUP); end
    end
    repeat (20) @(negedge clk);
    checks++; if (cs_lows - c0 !== 2) begin failures++; $display("FAIL t6_frames got=%0d want=2", cs_lows - c0); end
    checks++; if (dv_cnt - d0 !== 1) begin failures++; $display("FAIL t6_dv_count got=%0d want=1", dv_cnt - d0); end
    $display("test_same_channel ch=6 data=%h channel=%0d gap=%0d", adc_data, adc_channel, cs_high_min);
  endtask
`endif

  initial begin
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_frame();
    test_start_held();
`ifdef ADC_SAME_CH_EN
    test_same_channel();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
